// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response handshake plus word-organised data memory port
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readData,
        input  req_ready, resp_valid, resp_rdata, resp_error, MemWrite, MemRead, address, writeData
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, readData,
        output req_ready, resp_valid, resp_rdata, resp_error, MemWrite, MemRead, address, writeData
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine with read-modify-write for sub-word stores
module load_store_unit #(
    parameter int MEM_WORDS = 512
) (
    input logic clk,
    input logic rst_n,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t      state, next;
    logic [31:0] addr, wdata, old_word;
    logic [1:0]  size;
    logic        wr, uns, err;
    logic        req_err;
    logic [31:0] word_idx, mask, merged, ext;
    logic [4:0]  sh_b, sh_h, sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign req_err = bus.req_size == 2'b11
                   || (bus.req_size == 2'b01 && bus.req_addr[0])
                   || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                   || {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);

    assign word_idx = {2'b00, addr[31:2]};
    assign sh_b     = {addr[1:0], 3'b000};
    assign sh_h     = {addr[1], 4'b0000};
    assign sh       = size == 2'b01 ? sh_h : sh_b;
    assign byte_v   = 8'(old_word >> sh_b);
    assign half_v   = 16'(old_word >> sh_h);
    assign ext      = size == 2'b00 ? {{24{~uns & byte_v[7]}}, byte_v}
                    : size == 2'b01 ? {{16{~uns & half_v[15]}}, half_v}
                    : old_word;
    assign mask     = size == 2'b00 ? 32'h0000_00ff << sh_b
                    : size == 2'b01 ? 32'h0000_ffff << sh_h
                    : 32'hffff_ffff;
    assign merged   = (old_word & ~mask) | ((wdata << sh) & mask);

    // State register, request latch at accept, and capture of the memory word during READ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            addr     <= '0;
            wdata    <= '0;
            size     <= '0;
            wr       <= 1'b0;
            uns      <= 1'b0;
            err      <= 1'b0;
            old_word <= '0;
        end else begin
            state <= next;
            if (state == IDLE && bus.req_valid) begin
                addr  <= bus.req_addr;
                wdata <= bus.req_wdata;
                size  <= bus.req_size;
                wr    <= bus.req_write;
                uns   <= bus.req_unsigned;
                err   <= req_err;
            end
            if (state == READ)
                old_word <= bus.readData;
        end
    end

    // Next state and all outputs decoded purely from state and latched registers
    always_comb begin
        next           = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_error = 1'b0;
        bus.resp_rdata = '0;
        bus.MemRead    = 1'b0;
        bus.MemWrite   = 1'b0;
        bus.address    = '0;
        bus.writeData  = '0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid)
                    next = req_err ? RESP : (!bus.req_write || bus.req_size != 2'b10) ? READ : WRITE;
            end
            READ: begin
                bus.MemRead = 1'b1;
                bus.address = word_idx;
                next        = wr ? WRITE : RESP;
            end
            WRITE: begin
                bus.MemWrite  = 1'b1;
                bus.address   = word_idx;
                bus.writeData = merged;
                next          = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_error = err;
                bus.resp_rdata = (err || wr) ? 32'h0 : ext;
                next           = IDLE;
            end
        endcase
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access unit for the single-cycle processor's data path. It takes one load or store request at a time from the core over a valid/ready handshake and drives the word-organised data memory port (MemWrite, MemRead, address, writeData, readData). Byte and halfword stores are done as read-modify-write. Loads are lane-extracted and sign- or zero-extended. It returns one response per request, flagging misaligned or out-of-range accesses without touching memory.

## Interface
- MEM_WORDS, 512, number of 32-bit words in the data memory; legal word index range 0..MEM_WORDS-1
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  core presents a request
- req_ready  output  1  unit can accept; high only in IDLE
- req_write  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as misaligned
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle pulse, response present
- resp_rdata  output  32  extended load data; 0 for stores and errors
- resp_error  output  1  valid with resp_valid; misaligned, size 11, or out of range
- MemWrite  output  1  memory write strobe; memory writes at the clk edge where it is high
- MemRead  output  1  memory read enable
- address  output  32  word index = {2'b00, addr[31:2]}
- writeData  output  32  full word to write
- readData  input  32  combinational read data for the current address

## Operation
- States: IDLE, READ, WRITE, RESP.
- **IDLE**
  - req_ready = 1.
  - On req_valid, latch addr, size, write, unsigned and wdata.
  - Error check: size 11, half with addr[0] = 1, word with addr[1:0] ≠ 0, or word index ≥ MEM_WORDS. On error, go to RESP with the error flag set.
  - Otherwise: load → READ; word store → WRITE; byte or half store → READ.
- **READ**
  - MemRead = 1 and address = latched word index.
  - readData is registered into old_word at the clock edge.
  - Next state: loads → RESP; sub-word stores → WRITE.
- **WRITE**
  - MemWrite = 1. For a word store, writeData = wdata.
  - For a sub-word store, writeData = old_word with the lane replaced:
    - byte: lane k = addr[1:0], bits [8k+7:8k] ← wdata[7:0]
    - half: lane addr[1], bits [16h+15:16h] ← wdata[15:0]
  - Next state: RESP.
- **RESP**
  - resp_valid = 1.
  - resp_error = latched error flag.
  - resp_rdata:
    - loads: the lane of old_word, extended per size and unsigned
    - word loads: old_word
    - stores and errors: 0
  - Next state: IDLE. There is no backpressure on the response; the core must accept it.
- MemRead, MemWrite, address and writeData are decoded from state and latched registers only. Outside READ/WRITE: MemRead = MemWrite = 0, address = 0, writeData = 0.

## Timing
- Request accepted at edge E0 (req_valid & req_ready).
- Latency from E0 to the resp_valid cycle:
  - load: READ in cycle 1, RESP in cycle 2
  - word store: WRITE in cycle 1, RESP in cycle 2
  - sub-word store: READ, WRITE, RESP in cycles 1–3
  - error: RESP in cycle 1
- Throughput: the next request is accepted at the edge leaving RESP. req_ready goes high the cycle after resp_valid.
- A req_valid held while req_ready = 0 is ignored and not queued. The core holds it until accepted.
- Request inputs are sampled only at the accept edge. Later changes do not affect the operation in flight.
- **Reset values** (async, immediate):
  - state = IDLE, so req_ready = 1
  - resp_valid = 0, resp_rdata = 0, resp_error = 0
  - MemWrite = 0, MemRead = 0, address = 0, writeData = 0
  - all latched registers = 0
- Reset mid-operation aborts with no response. Assertion during WRITE drops MemWrite before the next edge, so no write occurs. A READ-then-WRITE pair is never split into a lone WRITE.

## Test plan
- Word store then load:
  - Stimulus: store addr 0x90, data 0xDEADBEEF.
  - Response: one-cycle MemWrite with address 36; resp after 2 cycles, error 0.
  - Then load word 0x90: resp_rdata 0xDEADBEEF, resp_valid in cycle 2.
- Byte store read-modify-write:
  - Stimulus: memory[36] = 0x11223344; store byte addr 0x92, data 0xAA.
  - Response: READ then WRITE with writeData 0x11AA3344; resp in cycle 3.
- Sign and zero extension on word 0x11AA3344:
  - load byte 0x92 signed → 0xFFFFFFAA
  - load byte 0x92 unsigned → 0x000000AA
  - load half 0x92 signed → 0x000011AA
- Error cases, each giving resp_error = 1 in cycle 1 with MemRead and MemWrite never asserted:
  - half load at 0x91
  - word store at 0x92
  - size 11
  - word load at 0x800 (index 512)
- Reset during the WRITE of a byte store:
  - Response: MemWrite falls immediately; memory word unchanged; no resp_valid; req_ready = 1 after release.
- Back-to-back requests with req_valid held high:
  - Response: exactly one accept per IDLE; req_ready is low during READ, WRITE and RESP; responses arrive in order.
